// File: rtl/ultrasonido_pkg.sv
// Shared definitions for the ultrasonic ranging path (trigger/divider and echo sides).
package ultrasonido_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE,
    DONE
  } echo_state_t;

  localparam int unsigned US_TICK_DIV_DEF     = 100;
  localparam int unsigned ECHO_TIMEOUT_US_DEF = 38000;

endpackage

// File: rtl/tick_gen_us.sv
// Microsecond prescaler: counting half of the divider, reused as a one-cycle tick strobe.
module tick_gen_us
  import ultrasonido_pkg::*;
#(
  parameter int unsigned TICK_DIV = US_TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;
  logic [PW-1:0] base;

  // clr together with en restarts the count and still counts the current cycle
  always_comb begin
    base = clr ? '0 : pre;
    tick = en && (base == PW'(TICK_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else if (en) begin
      pre <= base + PW'(1);
    end else begin
      pre <= base;
    end
  end

endmodule

// File: rtl/echo_meter.sv
// HC-SR04 echo receiver: synchronises the echo pin, times its high phase in
// microseconds and reports width/timeout with a one-cycle done strobe.
module echo_meter
  import ultrasonido_pkg::*;
#(
  parameter int unsigned TICK_DIV   = US_TICK_DIV_DEF,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TIMEOUT_US = ECHO_TIMEOUT_US_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             echo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] width_us,
  output logic             timeout
);

  echo_state_t      state;
  logic             echo_m, echo_s, echo_d;
  logic             rise, fall, clr, en, tick, hit;
  logic [WIDTH-1:0] us_cnt, us_next;

  tick_gen_us #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .tick (tick)
  );

  // The rise cycle both clears and counts, so N high cycles yield floor(N/TICK_DIV)
  always_comb begin
    rise    = echo_s & ~echo_d;
    fall    = ~echo_s & echo_d;
    clr     = ((state == IDLE) && start) || ((state == WAIT_RISE) && rise);
    en      = (state == WAIT_RISE) || (state == MEASURE);
    hit     = (us_cnt == WIDTH'(TIMEOUT_US));
    us_next = (clr ? '0 : us_cnt) + WIDTH'(tick);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      echo_m   <= 1'b0;
      echo_s   <= 1'b0;
      echo_d   <= 1'b0;
      us_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      width_us <= '0;
      timeout  <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
      us_cnt <= us_next;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT_RISE;
            busy     <= 1'b1;
            width_us <= '0;
            timeout  <= 1'b0;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            state <= MEASURE;
          end else if (hit) begin
            state    <= DONE;
            done     <= 1'b1;
            timeout  <= 1'b1;
            width_us <= '0;
          end
        end
        MEASURE: begin
          if (fall) begin
            state    <= DONE;
            done     <= 1'b1;
            timeout  <= 1'b0;
            width_us <= us_cnt;
          end else if (hit) begin
            state    <= DONE;
            done     <= 1'b1;
            timeout  <= 1'b1;
            width_us <= WIDTH'(TIMEOUT_US);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_meter.sv
// Self-checking bench for echo_meter with randomized pulse widths and a behavioural model.
module tb_echo_meter;

  localparam int TD    = 10;
  localparam int TO    = 600;
  localparam int LIMIT = 3 * TO * TD + 200;

  logic        clk = 1'b0;
  logic        rst_n, start, echo;
  logic        busy, done, timeout;
  logic [15:0] width_us;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  echo_meter #(.TICK_DIV(TD), .WIDTH(16), .TIMEOUT_US(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .echo    (echo),
    .busy    (busy),
    .done    (done),
    .width_us(width_us),
    .timeout (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected result from pulse geometry: delay to pin rise and pin-high length in cycles
  function automatic void model(input bit stuck, input int delay, input int n,
                                output int w, output bit to, output int lat);
    if (stuck || n == 0) begin
      w = 0; to = 1'b1; lat = TO * TD + 1;
    end else if (n <= TO * TD) begin
      w = n / TD; to = 1'b0; lat = delay + n + 3;
    end else begin
      w = TO; to = 1'b1; lat = delay + TO * TD + 3;
    end
  endfunction

  task automatic measure(input bit stuck, input int delay, input int n,
                         output int w, output bit to, output int lat,
                         output bit seen, output bit busy_after);
    int c;
    c = 0; seen = 1'b0; w = 0; to = 1'b0; lat = 0;
    if (stuck) begin
      echo = 1'b1;
      repeat (3) step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    while (!seen && c < LIMIT) begin
      echo = stuck || (c >= delay && c < delay + n);
      step();
      c++;
      if (done === 1'b1) begin
        seen = 1'b1; lat = c; w = int'(width_us); to = timeout;
      end
    end
    echo = 1'b0;
    step();
    busy_after = busy;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; echo = 1'b0;
    repeat (3) step();
    total++;
    if ({busy, done, timeout, width_us} !== 19'd0)
      $display("FAIL reset: busy=%b done=%b timeout=%b width=%0d, expected all 0", busy, done, timeout, width_us);
    else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_rise();
    bit bad = 1'b0;
    echo = 1'b1;
    repeat (20) begin step(); if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1; end
    echo = 1'b0;
    repeat (5) begin step(); if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1; end
    total++;
    if (bad) $display("FAIL idle_rise: activity seen without start, expected none");
    else passed++;
  endtask

  task automatic test_nominal();
    int w, ew, lat, elat; bit to, et, seen, ba;
    model(1'b0, 5, 5800, ew, et, elat);
    measure(1'b0, 5, 5800, w, to, lat, seen, ba);
    total++;
    if ({seen, to, 16'(w)} !== {1'b1, et, 16'(ew)})
      $display("FAIL nominal: seen=%b timeout=%b width=%0d, expected 1 %b %0d", seen, to, w, et, ew);
    else passed++;
    total++;
    if (lat !== elat) $display("FAIL nominal_latency: %0d cycles, expected %0d", lat, elat);
    else passed++;
    total++;
    if (ba !== 1'b0) $display("FAIL nominal_busy_drop: busy=%b after done, expected 0", ba);
    else passed++;
    total++;
    if (width_us !== 16'(ew)) $display("FAIL nominal_hold: width=%0d, expected %0d", width_us, ew);
    else passed++;
  endtask

  task automatic test_quantisation();
    int lens[3] = '{19, 20, 9};
    int w, ew, lat, elat; bit to, et, seen, ba;
    foreach (lens[i]) begin
      model(1'b0, 7, lens[i], ew, et, elat);
      measure(1'b0, 7, lens[i], w, to, lat, seen, ba);
      total++;
      if ({seen, to, 16'(w)} !== {1'b1, et, 16'(ew)} || lat !== elat)
        $display("FAIL quant_%0d: seen=%b timeout=%b width=%0d lat=%0d, expected 1 %b %0d %0d",
                 lens[i], seen, to, w, lat, et, ew, elat);
      else passed++;
    end
  endtask

  task automatic test_no_echo();
    int w, ew, lat, elat; bit to, et, seen, ba;
    model(1'b0, 0, 0, ew, et, elat);
    measure(1'b0, 0, 0, w, to, lat, seen, ba);
    total++;
    if ({seen, to, 16'(w)} !== {1'b1, et, 16'(ew)})
      $display("FAIL no_echo: seen=%b timeout=%b width=%0d, expected 1 %b %0d", seen, to, w, et, ew);
    else passed++;
    total++;
    if (lat !== elat) $display("FAIL no_echo_latency: %0d cycles, expected %0d", lat, elat);
    else passed++;
  endtask

  task automatic test_stuck_high();
    int w, ew, lat, elat; bit to, et, seen, ba;
    model(1'b1, 0, 0, ew, et, elat);
    measure(1'b1, 0, 0, w, to, lat, seen, ba);
    total++;
    if ({seen, to, 16'(w)} !== {1'b1, et, 16'(ew)} || lat !== elat)
      $display("FAIL stuck_before_start: seen=%b timeout=%b width=%0d lat=%0d, expected 1 %b %0d %0d",
               seen, to, w, lat, et, ew, elat);
    else passed++;
    model(1'b0, 5, 10 * TO * TD, ew, et, elat);
    measure(1'b0, 5, 10 * TO * TD, w, to, lat, seen, ba);
    total++;
    if ({seen, to, 16'(w)} !== {1'b1, et, 16'(ew)} || lat !== elat)
      $display("FAIL stuck_after_rise: seen=%b timeout=%b width=%0d lat=%0d, expected 1 %b %0d %0d",
               seen, to, w, lat, et, ew, elat);
    else passed++;
  endtask

  task automatic test_boundary();
    int lens[2] = '{TO * TD, TO * TD + 1};
    int w, ew, lat, elat; bit to, et, seen, ba;
    foreach (lens[i]) begin
      model(1'b0, 4, lens[i], ew, et, elat);
      measure(1'b0, 4, lens[i], w, to, lat, seen, ba);
      total++;
      if ({seen, to, 16'(w)} !== {1'b1, et, 16'(ew)} || lat !== elat)
        $display("FAIL boundary_%0d: seen=%b timeout=%b width=%0d lat=%0d, expected 1 %b %0d %0d",
                 lens[i], seen, to, w, lat, et, ew, elat);
      else passed++;
    end
  endtask

  task automatic test_random();
    int w, ew, lat, elat, n, d; bit to, et, seen, ba;
    repeat (8) begin
      n = int'($urandom_range(400, 1));
      d = int'($urandom_range(60, 2));
      model(1'b0, d, n, ew, et, elat);
      measure(1'b0, d, n, w, to, lat, seen, ba);
      total++;
      if ({seen, to, 16'(w)} !== {1'b1, et, 16'(ew)} || ba !== 1'b0)
        $display("FAIL random_n%0d: seen=%b timeout=%b width=%0d busy_after=%b, expected 1 %b %0d 0",
                 n, seen, to, w, ba, et, ew);
      else passed++;
      total++;
      if (lat !== elat) $display("FAIL random_latency_n%0d: %0d cycles, expected %0d", n, lat, elat);
      else passed++;
    end
  endtask

  task automatic test_ignored_start();
    int c = 0, ndone = 0, w = 0, ew, elat; bit to = 1'b0, et, extra = 1'b0;
    model(1'b0, 5, 150, ew, et, elat);
    start = 1'b1;
    step();
    // start stays high through WAIT_RISE, MEASURE and the DONE cycle
    while (ndone == 0 && c < LIMIT) begin
      echo = (c >= 5 && c < 155);
      step();
      c++;
      if (done === 1'b1) begin ndone++; w = int'(width_us); to = timeout; end
    end
    step();
    start = 1'b0; echo = 1'b0;
    repeat (40) begin
      step();
      if (done === 1'b1) ndone++;
      if (busy !== 1'b0) extra = 1'b1;
    end
    total++;
    if (ndone !== 1) $display("FAIL ignored_done_count: %0d, expected 1", ndone);
    else passed++;
    total++;
    if (extra) $display("FAIL ignored_requeue: busy reasserted, expected 0");
    else passed++;
    total++;
    if ({to, 16'(w)} !== {et, 16'(ew)} || width_us !== 16'(ew))
      $display("FAIL ignored_result: timeout=%b width=%0d held=%0d, expected %b %0d", to, w, width_us, et, ew);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int w, ew, lat, elat; bit to, et, seen, ba;
    start = 1'b1;
    step();
    start = 1'b0; echo = 1'b1;
    repeat (100) step();
    total++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy: busy=%b before reset, expected 1", busy);
    else passed++;
    rst_n = 1'b0;
    step();
    total++;
    if ({busy, done, timeout, width_us} !== 19'd0)
      $display("FAIL reset_mid: busy=%b done=%b timeout=%b width=%0d, expected all 0", busy, done, timeout, width_us);
    else passed++;
    rst_n = 1'b1; echo = 1'b0;
    repeat (3) step();
    model(1'b0, 10, 300, ew, et, elat);
    measure(1'b0, 10, 300, w, to, lat, seen, ba);
    total++;
    if ({seen, to, 16'(w)} !== {1'b1, et, 16'(ew)} || lat !== elat)
      $display("FAIL reset_mid_remeasure: seen=%b timeout=%b width=%0d lat=%0d, expected 1 %b %0d %0d",
               seen, to, w, lat, et, ew, elat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_rise();
    test_nominal();
    test_quantisation();
    test_no_echo();
    test_stuck_high();
    test_boundary();
    test_random();
    test_ignored_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/echo_meter.md
# echo_meter

Measures the width of the HC-SR04 ultrasonic echo pulse in microseconds and reports it with a one-cycle `done` strobe. It is the receive side of the ultrasonic ranging path. The divider/trigger logic launches the 10 us ping. This block synchronises the returning `echo` pin, times its high phase with an internal 1 us prescaler, and flags a timeout when no echo or an overlong echo occurs. Distance conversion (width/58 = cm) is done downstream.

## Interface
- `TICK_DIV`, 100 — clk cycles per microsecond tick (100 MHz / 1 MHz).
- `WIDTH`, 16 — width of the microsecond counter and of `width_us`.
- `TIMEOUT_US`, 38000 — limit for each of the wait-for-echo and echo-high phases. Must be below 2**WIDTH.
- `clk` input 1 — system clock, 100 MHz.
- `rst_n` input 1 — synchronous, active-low reset.
- `start` input 1 — one-cycle request to arm a measurement. Honoured only while `busy`=0.
- `echo` input 1 — asynchronous sensor echo pin.
- `busy` output 1 — high from the cycle after `start` is accepted until the cycle after `done`.
- `done` output 1 — one-cycle strobe. `width_us` and `timeout` are valid in this cycle.
- `width_us` output WIDTH — measured high time in microseconds. Held until the next accepted `start`.
- `timeout` output 1 — set when the measurement ended by timeout. Held like `width_us`.

## Operation
- Synchroniser: two flops give `echo_s`. A third flop gives `echo_d`.
  - rise = `echo_s & ~echo_d`
  - fall = `~echo_s & echo_d`
  - All three flops reset to 0.
- Prescaler `pre`: counts 0..TICK_DIV-1 while enabled. On reaching TICK_DIV-1 it wraps to 0 and pulses `tick`. It is cleared on entry to WAIT_RISE and on the rise cycle.
- Microsecond counter `us_cnt`: increments on `tick` and is cleared together with `pre`.
- FSM states: IDLE, WAIT_RISE, MEASURE, DONE.
  - IDLE, `start`=1: go to WAIT_RISE. Clear `pre`, `us_cnt`, `width_us` and `timeout`.
  - WAIT_RISE, rise: go to MEASURE. Clear `pre` and `us_cnt`; the rise cycle is the first counted cycle.
  - WAIT_RISE, `us_cnt`==TIMEOUT_US: go to DONE with `timeout`=1 and `width_us`=0.
  - MEASURE, fall: go to DONE with `width_us`=`us_cnt` and `timeout`=0. The fall cycle is not counted.
  - MEASURE, `us_cnt`==TIMEOUT_US and no fall: go to DONE with `timeout`=1 and `width_us`=TIMEOUT_US (saturated).
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Result: for an echo high for N clk cycles, `width_us` = floor(N / TICK_DIV).
- Edge and boundary rules:
  - An echo already high when `start` is accepted produces no rise. The measurement times out in WAIT_RISE.
  - A rise during IDLE is ignored.
  - If fall and the timeout compare hit in the same cycle, fall wins: `timeout`=0, `width_us`=TIMEOUT_US.
  - `start` while `busy` is ignored and does not queue.
  - `start` in the DONE cycle is ignored.
- Reset, including mid-measurement, on the next edge:
  - FSM to IDLE.
  - `busy`=0, `done`=0, `width_us`=0, `timeout`=0.
  - `pre`, `us_cnt` and synchroniser flops cleared.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `width_us`=0, `timeout`=0.
- `start` sampled high at edge k: `busy` is high after edge k.
- Pin edge to detection: 2 clk edges (two-flop synchroniser). Detection to FSM transition: 1 edge.
- `done` is high in the cycle after the 3rd clk edge that samples `echo` low.
- `busy` drops on the edge after `done`. A new `start` is accepted in that cycle.
- Timeout latency, WAIT_RISE: `done` exactly TIMEOUT_US*TICK_DIV+1 cycles after `busy` rises.
- Throughput: one measurement per start. There is no back-to-back pipelining.

## Structure
- Package `ultrasonido_pkg`:
  - State enum `echo_state_t` {IDLE, WAIT_RISE, MEASURE, DONE}.
  - Constants `US_TICK_DIV_DEF`=100 and `ECHO_TIMEOUT_US_DEF`=38000, shared with the trigger/divider side.
- Sub-module `tick_gen_us`: the prescaler, with inputs `clk`, `rst_n`, `clr`, `en` and output `tick`. It is the counting half of the divider reused as a strobe.
- Everything else stays in `echo_meter`.

## Test plan
Benches use `TICK_DIV`=100 and `TIMEOUT_US`=1000 unless noted.
- Nominal: `start`, `echo` rises 50 cycles later and stays high 58000 cycles -> one `done` with `width_us`=580, `timeout`=0, `busy` low the next cycle.
- Quantisation: echo high 199 cycles -> `width_us`=1. Echo high 200 cycles -> `width_us`=2. Echo high 99 cycles -> `width_us`=0, `timeout`=0.
- No echo: `start`, `echo` held 0 -> `done` at 100001 cycles after `busy`, `timeout`=1, `width_us`=0.
- Stuck high: `echo`=1 before `start` -> WAIT_RISE timeout, `timeout`=1. Echo rising after start and held high -> `timeout`=1, `width_us`=1000.
- Ignored requests: `start` pulses during MEASURE and DONE -> exactly one `done` per accepted `start`, results unchanged.
- Reset mid-MEASURE: `rst_n`=0 for one cycle -> all outputs 0 on the next edge. A fresh `start` then measures a 300-cycle pulse as `width_us`=3.
